// File: rtl/key_matrix_scanner.sv
// Keypad matrix scanner: one-cold column strobing, whole-matrix debounce per scan
// frame, and a first-word-fall-through FIFO of encoded press/release events.
module key_matrix_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE       = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPORT_RELEASE = 0,
    localparam int NK  = ROWS * COLS,
    localparam int CW  = $clog2(NK),
    localparam int AW  = $clog2(FIFO_DEPTH),
    localparam int CLW = $clog2(COLS),
    localparam int DW  = $clog2(SCAN_DIV)
) (
    input  logic            clk_init,
    input  logic            rst_init,
    input  logic [ROWS-1:0] btn_key_row,
    output logic [COLS-1:0] btn_key_col,
    input  logic            key_rd,
    output logic            key_valid,
    output logic [CW:0]     key_code,
    output logic [AW:0]     key_count,
    output logic            key_down,
    output logic            overflow
);

    typedef logic [CW:0] code_t;

    logic [ROWS-1:0] sync1_q, sync2_q;
    logic [CLW-1:0]  col_q, col_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [NK-1:0]   frame_q, frame_d;
    logic [NK-1:0]   last_frame_q, last_frame_d;
    logic [NK-1:0]   stable_q, stable_d;
    logic [NK-1:0]   pend_press_q, pend_press_d;
    logic [NK-1:0]   pend_rel_q, pend_rel_d;
    logic            frame_done_q, frame_done_d;
    logic [3:0]      stab_cnt_q, stab_cnt_d;
    code_t           mem_q [FIFO_DEPTH];
    code_t           mem_d [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    code_t           key_code_q, key_code_d;
    logic            overflow_q, overflow_d;

    logic            sample, commit;
    logic [NK-1:0]   rose, fell;
    logic            press_any, rel_any, ev_valid, push, pop, full;
    logic [CW-1:0]   press_idx, rel_idx;
    code_t           ev_code;

    assign btn_key_col = ~(COLS'(1) << col_q);
    assign key_valid   = (count_q != '0);
    assign key_code    = key_code_q;
    assign key_count   = count_q;
    assign key_down    = |stable_q;
    assign overflow    = overflow_q;

    // Scan timing and frame capture; rows are sampled at the end of each column dwell.
    always_comb begin
        sample  = (dwell_q == DW'(SCAN_DIV - 1));
        dwell_d = sample ? '0 : dwell_q + 1'b1;
        col_d   = col_q;
        frame_d = frame_q;
        if (sample) begin
            col_d = (col_q == CLW'(COLS - 1)) ? '0 : col_q + 1'b1;
            for (int r = 0; r < ROWS; r++)
                frame_d[r*COLS + int'(col_q)] = ~sync2_q[r];
        end
        frame_done_d = sample && (col_q == CLW'(COLS - 1));
    end

    // Debounce: commit only on the frame where the stable run first reaches DEBOUNCE.
    always_comb begin
        stab_cnt_d   = stab_cnt_q;
        last_frame_d = last_frame_q;
        stable_d     = stable_q;
        commit       = 1'b0;
        if (frame_done_q) begin
            last_frame_d = frame_q;
            if (frame_q != last_frame_q) begin
                stab_cnt_d = '0;
            end else if (stab_cnt_q != 4'(DEBOUNCE)) begin
                stab_cnt_d = stab_cnt_q + 1'b1;
                commit     = (stab_cnt_q == 4'(DEBOUNCE - 1));
            end
            if (commit) stable_d = frame_q;
        end
        rose = commit ? (frame_q & ~stable_q) : '0;
        fell = (commit && REPORT_RELEASE != 0) ? (~frame_q & stable_q) : '0;
    end

    // Event issue: presses before releases, lowest index first within a class.
    always_comb begin
        press_idx = '0;
        rel_idx   = '0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (pend_press_q[i]) press_idx = CW'(i);
            if (pend_rel_q[i])   rel_idx   = CW'(i);
        end
        press_any = |pend_press_q;
        rel_any   = |pend_rel_q;
        ev_valid  = press_any || rel_any;
        ev_code   = press_any ? {1'b0, press_idx} : {1'b1, rel_idx};

        pend_press_d = pend_press_q;
        pend_rel_d   = pend_rel_q;
        if (press_any)    pend_press_d[press_idx] = 1'b0;
        else if (rel_any) pend_rel_d[rel_idx]     = 1'b0;
        pend_press_d = pend_press_d | rose;
        pend_rel_d   = pend_rel_d | fell;
    end

    // FIFO: a pop in the same cycle frees the slot for a push into a full FIFO.
    always_comb begin
        pop        = key_rd && (count_q != '0);
        full       = (count_q == (AW+1)'(FIFO_DEPTH));
        push       = ev_valid && (!full || pop);
        overflow_d = overflow_q || (ev_valid && full && !pop);
        mem_d      = mem_q;
        if (push) mem_d[wr_ptr_q] = ev_code;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        key_code_d = (count_d != '0) ? mem_d[rd_ptr_d] : key_code_q;
    end

    always_ff @(posedge clk_init) begin
        if (!rst_init) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            col_q        <= '0;
            dwell_q      <= '0;
            frame_q      <= '0;
            last_frame_q <= '0;
            stable_q     <= '0;
            pend_press_q <= '0;
            pend_rel_q   <= '0;
            frame_done_q <= 1'b0;
            stab_cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            key_code_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= btn_key_row;
            sync2_q      <= sync1_q;
            col_q        <= col_d;
            dwell_q      <= dwell_d;
            frame_q      <= frame_d;
            last_frame_q <= last_frame_d;
            stable_q     <= stable_d;
            pend_press_q <= pend_press_d;
            pend_rel_q   <= pend_rel_d;
            frame_done_q <= frame_done_d;
            stab_cnt_q   <= stab_cnt_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            key_code_q   <= key_code_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner: a key-matrix model drives the rows of two
// instances (release reporting off / on) sharing one key state and reset.
module tb_key_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] keys;
    logic        key_rd, key_rd_r;

    logic [3:0] row_a, col_a, row_b, col_b;
    logic       valid_a, down_a, ovf_a, valid_b, down_b, ovf_b;
    logic [4:0] code_a, code_b;
    logic [2:0] count_a, count_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    // A row reads low while a pressed key on it has its column strobed low.
    always_comb begin
        row_a = '1;
        row_b = '1;
        for (int r = 0; r < 4; r++) begin
            row_a[r] = ~|(keys[r*4 +: 4] & ~col_a);
            row_b[r] = ~|(keys[r*4 +: 4] & ~col_b);
        end
    end

    // Cycle index since reset release; cycle c has col = (c/4)%4, frame = c/16.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    key_matrix_scanner u_dut (
        .clk_init(clk), .rst_init(rst_n), .btn_key_row(row_a), .btn_key_col(col_a),
        .key_rd(key_rd), .key_valid(valid_a), .key_code(code_a), .key_count(count_a),
        .key_down(down_a), .overflow(ovf_a)
    );

    key_matrix_scanner #(.REPORT_RELEASE(1)) u_rel (
        .clk_init(clk), .rst_init(rst_n), .btn_key_row(row_b), .btn_key_col(col_b),
        .key_rd(key_rd_r), .key_valid(valid_b), .key_code(code_b), .key_count(count_b),
        .key_down(down_b), .overflow(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("wait_cyc", cyc, n);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, valid_a, 0);
        check({tag, "_code"},  code_a,  0);
        check({tag, "_count"}, count_a, 0);
        check({tag, "_down"},  down_a,  0);
        check({tag, "_ovf"},   ovf_a,   0);
    endtask

    initial begin
        rst_n = 1'b0; keys = '0; key_rd = 1'b0; key_rd_r = 1'b0;

        // Reset state and column walk
        repeat (10) @(negedge clk);
        check("rst_col", col_a, 4'b1110);
        check_idle("rst");
        rst_n = 1'b1;
        check("rel_col", col_a, 4'b1110);
        check_idle("rel");
        wait_cyc(3);  check("walk3",  col_a, 4'b1110);
        wait_cyc(4);  check("walk4",  col_a, 4'b1101);
        wait_cyc(8);  check("walk8",  col_a, 4'b1011);
        wait_cyc(12); check("walk12", col_a, 4'b0111);
        wait_cyc(16); check("walk16", col_a, 4'b1110);

        // Single press of key 0 from frame 1; commit at cycle 80
        keys[0] = 1'b1;
        wait_cyc(80); check("sp_down80", down_a, 0);
        wait_cyc(81); check("sp_down81", down_a, 1); check("sp_valid81", valid_a, 0);
        wait_cyc(82); check("sp_valid82", valid_a, 1); check("sp_code", code_a, 5'h00);
        check("sp_count", count_a, 1); check("sp_rel_valid", valid_b, 1);
        wait_cyc(100); key_rd = 1'b1; key_rd_r = 1'b1;
        wait_cyc(101); key_rd = 1'b0; key_rd_r = 1'b0;
        check("sp_pop_valid", valid_a, 0); check("sp_pop_code", code_a, 5'h00);
        wait_cyc(111); check("sp_one_event", count_a, 0);

        // Release of key 0 from frame 7; commit at cycle 176
        wait_cyc(112); keys[0] = 1'b0;
        wait_cyc(176); check("rl_down176", down_a, 1);
        wait_cyc(177); check("rl_down177", down_a, 0);
        wait_cyc(178); check("rl_rel_valid", valid_b, 1); check("rl_rel_code", code_b, 5'h10);
        check("rl_norel_valid", valid_a, 0); check("rl_norel_count", count_a, 0);
        wait_cyc(180); key_rd_r = 1'b1;
        wait_cyc(181); key_rd_r = 1'b0;

        // Bounce on key 15 for frames 12..19, then held from frame 20
        for (int i = 0; i < 8; i++) begin
            wait_cyc(192 + 16*i);
            keys[15] = (i % 2 == 0);
        end
        wait_cyc(320); keys[15] = 1'b1;
        check("bn_quiet_valid", valid_a, 0); check("bn_quiet_count", count_a, 0);
        wait_cyc(384); check("bn_down384", down_a, 0);
        wait_cyc(385); check("bn_valid385", valid_a, 0); check("bn_down385", down_a, 1);
        wait_cyc(386); check("bn_valid386", valid_a, 1); check("bn_code", code_a, 5'h0F);
        check("bn_count", count_a, 1);
        wait_cyc(390); key_rd = 1'b1;
        wait_cyc(391); key_rd = 1'b0; check("bn_popped", count_a, 0);
        wait_cyc(400); keys[15] = 1'b0;

        // Rollover: keys 5, 2, 9 from frame 30; commit at cycle 544
        wait_cyc(480); keys[5] = 1'b1; keys[2] = 1'b1; keys[9] = 1'b1;
        wait_cyc(544); check("ro_valid544", valid_a, 0);
        wait_cyc(546); check("ro_code546", code_a, 5'h02); check("ro_count546", count_a, 1);
        wait_cyc(547); check("ro_count547", count_a, 2);
        wait_cyc(548); check("ro_count548", count_a, 3); check("ro_code548", code_a, 5'h02);
        key_rd = 1'b1;
        wait_cyc(549); check("ro_code549", code_a, 5'h05);
        wait_cyc(550); check("ro_code550", code_a, 5'h09);
        wait_cyc(551); key_rd = 1'b0;
        check("ro_empty", valid_a, 0); check("ro_hold", code_a, 5'h09);

        // Overflow: keys 10..15 from frame 36; commit at cycle 640
        wait_cyc(576); keys[15:10] = 6'h3F;
        wait_cyc(645); check("of_count645", count_a, 4); check("of_ovf645", ovf_a, 0);
        wait_cyc(646); check("of_ovf646", ovf_a, 1);
        wait_cyc(650); check("of_count650", count_a, 4); check("of_code650", code_a, 5'h0A);
        key_rd = 1'b1;
        wait_cyc(651); check("of_code651", code_a, 5'h0B);
        wait_cyc(652); check("of_code652", code_a, 5'h0C);
        wait_cyc(653); check("of_code653", code_a, 5'h0D);
        wait_cyc(654); key_rd = 1'b0;
        check("of_empty", valid_a, 0); check("of_sticky", ovf_a, 1);

        // Push and pop together at full after a fresh reset
        @(negedge clk); rst_n = 1'b0; keys = '0;
        repeat (5) @(negedge clk);
        check("r2_ovf", ovf_a, 0); check("r2_count", count_a, 0);
        rst_n = 1'b1;
        wait_cyc(16); keys[4:0] = 5'h1F;
        wait_cyc(84); check("pp_count84", count_a, 3);
        wait_cyc(85); check("pp_count85", count_a, 4); check("pp_code85", code_a, 5'h00);
        key_rd = 1'b1;
        wait_cyc(86); key_rd = 1'b0;
        check("pp_count86", count_a, 4); check("pp_code86", code_a, 5'h01);
        check("pp_ovf86", ovf_a, 0);
        wait_cyc(90); key_rd = 1'b1;
        wait_cyc(91); check("pp_code91", code_a, 5'h02);
        wait_cyc(92); check("pp_code92", code_a, 5'h03);
        wait_cyc(93); check("pp_code93", code_a, 5'h04);
        wait_cyc(94); key_rd = 1'b0;
        check("pp_empty", valid_a, 0); check("pp_ovf94", ovf_a, 0);

        // Reset mid-frame while events are still pending
        wait_cyc(112); keys = 16'h01C0;
        wait_cyc(178); check("mr_count", count_a, 1); check("mr_code", code_a, 5'h06);
        rst_n = 1'b0; keys = '0;
        repeat (3) @(negedge clk);
        check("mr_rst_valid", valid_a, 0); check("mr_rst_count", count_a, 0);
        rst_n = 1'b1;
        check("mr_col", col_a, 4'b1110);
        wait_cyc(1);   check_idle("mr_c1");
        wait_cyc(100); check_idle("mr_c100");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Parametrised keypad-matrix scanner for the MiniMIPS32 SoC peripheral bus. It drives active-low column strobes (`btn_key_col`) and samples active-low row returns (`btn_key_row`). It debounces the whole matrix per scan frame and queues encoded press and release events in a first-word-fall-through FIFO, which the CPU-side peripheral logic pops. It replaces the fixed 4x4 single-key read path and supports any ROWS x COLS matrix, multi-key rollover and optional release reporting.

## Interface
- ROWS, default 4: number of row inputs (>=1).
- COLS, default 4: number of column strobes (>=2).
- SCAN_DIV, default 4: clock cycles each column stays strobed (>=3).
- DEBOUNCE, default 3: consecutive identical frames required before the matrix commits (1..15).
- FIFO_DEPTH, default 4: event FIFO entries, power of 2 (>=2).
- REPORT_RELEASE, default 0: 1 enables queuing of release events.
- CW = clog2(ROWS*COLS) (derived).

Ports:
- clk_init, input, 1: sole clock.
- rst_init, input, 1: synchronous, active-low reset.
- btn_key_row, input, ROWS: row returns, active-low, asynchronous to clk_init.
- btn_key_col, output, COLS: column strobes, one-cold.
- key_rd, input, 1: pops the FIFO head. Ignored when key_valid=0.
- key_valid, output, 1: FIFO not empty.
- key_code, output, CW+1: FIFO head. Bit CW is 1 for a release and 0 for a press. Bits [CW-1:0] hold row*COLS+col.
- key_count, output, clog2(FIFO_DEPTH)+1: FIFO occupancy.
- key_down, output, 1: at least one key is set in the committed matrix.
- overflow, output, 1: sticky flag. Set when an event is dropped. Cleared only by reset.

## Operation
- Row inputs pass through a 2-flop synchroniser before any use.
- Column counter `col` runs 0..COLS-1 and wraps to 0. A dwell counter runs 0..SCAN_DIV-1. `btn_key_col = ~(1<<col)`.
- At dwell SCAN_DIV-1, the synchronised rows are inverted and written into `frame[row][col]`. After that sample, `col` advances.
- The frame ends (cycle E) when column COLS-1 is sampled.
- Debounce at E+1:
  - If `frame` differs from `last_frame`, the stable counter clears to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE.
  - `last_frame` is then updated to `frame`.
  - On the transition to DEBOUNCE (counter was DEBOUNCE-1), `stable` takes `frame` and commits.
- On a commit:
  - Every 0->1 bit of `stable` is ORed into `pend_press`.
  - If REPORT_RELEASE=1, every 1->0 bit is ORed into `pend_rel`.
- Event issue: one event per cycle.
  - Press events take priority over release events.
  - Within a class, the lowest index goes first.
  - The issued bit clears in the same cycle.
- Push rules:
  - If the FIFO is full and no pop occurs that cycle, the event is dropped, its pending bit still clears, and `overflow` sets.
  - If the FIFO is full and a pop occurs in the same cycle, the push succeeds.
- Pop: `key_rd` while `key_valid` removes the head. The next entry appears in key_code on the following cycle.
- key_code holds its last value when the FIFO is empty.
- Reset mid-scan or mid-event clears everything: `frame`, `last_frame`, `stable`, pending masks, the FIFO, and all counters.

## Timing
- Frame length is COLS*SCAN_DIV cycles. One sweep takes 16 cycles at default parameters.
- Values while rst_init=0, and in the first cycle after release:
  - btn_key_col = all ones except bit 0 = 0 (4'b1110).
  - key_valid=0, key_code=0, key_count=0, key_down=0, overflow=0.
- Press latency:
  - A matrix state first captured in frame k commits at E(k+DEBOUNCE)+1.
  - The first event is pushed at the next edge, and key_valid rises 1 cycle later, i.e. at E+3.
  - key_down rises at E+2.
- A change shorter than DEBOUNCE frames never commits and produces no events.
- N simultaneous new presses from one commit produce N events in N consecutive cycles, in ascending code order.
- key_count updates 1 cycle after each push or pop. On a simultaneous push and pop, key_count is unchanged.

## Test plan
Default parameters unless stated. The bench models the matrix: a row reads 0 while a pressed key's column is strobed low.
- Reset: hold rst_init=0 for 10 cycles, then release. Required: btn_key_col=4'b1110, all outputs 0, and the strobe walks 1110->1101->1011->0111 with 4 cycles per column.
- Single press: hold key (row0,col0) for 6 frames. Required: exactly one event, key_code=5'h00, key_valid rises at E+3 of frame k+3, and key_down=1. Then release the key: REPORT_RELEASE=0 gives no event; REPORT_RELEASE=1 gives key_code=5'h10.
- Bounce: toggle key (3,3) every frame for 8 frames, then hold it. Required: no event during the toggling, then a single event 5'h0F after 3 stable frames.
- Rollover: press keys 5, 2 and 9 within the same frame. Required: key_code sequence 2, 5, 9 on consecutive cycles, and key_count reaches 3.
- Overflow: with key_rd=0, trigger 6 presses. Required: FIFO holds the first 4 codes, key_count=4, overflow=1 and stays 1. Popping 4 entries returns them in order, then key_valid=0.
- Simultaneous push and pop at full: the push is accepted, key_count stays 4, overflow stays 0. Asserting rst_init=0 mid-frame clears the FIFO and pending events, and no stale event appears after reset is released.
